// File: rtl/mcl51_pkg.sv
// Shared constants for the MCL51 bus interface unit: EU command codes, SFR addresses,
// PSW bit positions and the read-source tag used by the return-data pipeline.
package mcl51_pkg;

  localparam logic [7:0] BIU_CMD_IDLE     = 8'h00;
  localparam logic [7:0] BIU_CMD_CODE_IP  = 8'h01;
  localparam logic [7:0] BIU_CMD_CODE_R3  = 8'h02;
  localparam logic [7:0] BIU_CMD_DIR_RD   = 8'h03;
  localparam logic [7:0] BIU_CMD_DIR_WR   = 8'h04;
  localparam logic [7:0] BIU_CMD_IND_RD   = 8'h05;
  localparam logic [7:0] BIU_CMD_IND_WR   = 8'h06;
  localparam logic [7:0] BIU_CMD_ACC_WR   = 8'h07;
  localparam logic [7:0] BIU_CMD_PSW_WR   = 8'h08;
  localparam logic [7:0] BIU_CMD_SP_WR    = 8'h09;
  localparam logic [7:0] BIU_CMD_DPL_WR   = 8'h0A;
  localparam logic [7:0] BIU_CMD_DPH_WR   = 8'h0B;
  localparam logic [7:0] BIU_CMD_INT_ACK  = 8'h0C;
  localparam logic [7:0] BIU_CMD_RETI     = 8'h0D;
  localparam logic [7:0] BIU_CMD_XDATA_RD = 8'h0E;
  localparam logic [7:0] BIU_CMD_XDATA_WR = 8'h0F;

  localparam logic [7:0] SFR_SP_ADDR  = 8'h81;
  localparam logic [7:0] SFR_DPL_ADDR = 8'h82;
  localparam logic [7:0] SFR_DPH_ADDR = 8'h83;
  localparam logic [7:0] SFR_P1_ADDR  = 8'h90;
  localparam logic [7:0] SFR_IE_ADDR  = 8'hA8;
  localparam logic [7:0] SFR_PSW_ADDR = 8'hD0;
  localparam logic [7:0] SFR_ACC_ADDR = 8'hE0;
  localparam logic [7:0] SFR_B_ADDR   = 8'hF0;

  localparam int unsigned PSW_P   = 0;
  localparam int unsigned PSW_OV  = 2;
  localparam int unsigned PSW_RS0 = 3;
  localparam int unsigned PSW_RS1 = 4;
  localparam int unsigned PSW_F0  = 5;
  localparam int unsigned PSW_AC  = 6;
  localparam int unsigned PSW_CY  = 7;

  typedef enum logic [2:0] {SrcZero, SrcCode, SrcIram, SrcSfr, SrcXdata} rd_src_e;

endpackage

// File: rtl/mcl51_biu_if.sv
// EU <-> BIU strobe interface: the EU (master) issues commands, the BIU (slave) answers
// with return data, SFR views and the interrupt request.
interface mcl51_biu_if;
  logic [7:0]  EU_BIU_STROBE;
  logic [7:0]  EU_BIU_DATAOUT;
  logic [15:0] EU_REGISTER_R3;
  logic [15:0] EU_REGISTER_IP;
  logic [7:0]  BIU_RETURN_DATA;
  logic [7:0]  BIU_SFR_ACC;
  logic [15:0] BIU_SFR_DPTR;
  logic [7:0]  BIU_SFR_SP;
  logic [7:0]  BIU_SFR_PSW;
  logic        BIU_INTERRUPT;

  modport master (
    output EU_BIU_STROBE, EU_BIU_DATAOUT, EU_REGISTER_R3, EU_REGISTER_IP,
    input  BIU_RETURN_DATA, BIU_SFR_ACC, BIU_SFR_DPTR, BIU_SFR_SP, BIU_SFR_PSW, BIU_INTERRUPT
  );

  modport slave (
    input  EU_BIU_STROBE, EU_BIU_DATAOUT, EU_REGISTER_R3, EU_REGISTER_IP,
    output BIU_RETURN_DATA, BIU_SFR_ACC, BIU_SFR_DPTR, BIU_SFR_SP, BIU_SFR_PSW, BIU_INTERRUPT
  );
endinterface

// File: rtl/mcl51_biu_iram.sv
// Internal RAM: Depth x 8 synchronous single-port array with registered (1-cycle) read.
module mcl51_biu_iram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk,
  input  logic [Aw-1:0] addr,
  input  logic          we,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mcl51_biu.sv
// MCL51 bus interface unit: decodes EU strobes, owns the SFRs, serves code/IRAM/SFR reads.
// Optional external data memory (MOVX) support is enabled with MCL51_BIU_XDATA_EN.
module mcl51_biu
  import mcl51_pkg::*;
#(
  parameter int unsigned CODE_AW    = 16,
  parameter int unsigned IRAM_DEPTH = 256,
  parameter logic [7:0]  SP_RESET   = 8'h07
) (
  input  logic               CORE_CLK,
  input  logic               RST_n,
  mcl51_biu_if.slave         eu,
  output logic [CODE_AW-1:0] CODE_ADDR,
  input  logic [7:0]         CODE_DATA,
  input  logic               INT0_n,
  input  logic               INT1_n,
  output logic [7:0]         P1_OUT
`ifdef MCL51_BIU_XDATA_EN
  ,
  output logic [15:0]        XDATA_ADDR,
  output logic [7:0]         XDATA_WDATA,
  output logic               XDATA_WE,
  input  logic [7:0]         XDATA_RDATA
`endif
);
  localparam int unsigned IramAw   = $clog2(IRAM_DEPTH);
  localparam bit          HasUpper = (IRAM_DEPTH > 128);

  logic               live_q;
  logic [7:0]         strobe_q, cmd, daddr, wdata;
  logic [7:0]         acc_q, acc_d, b_q, b_d, sp_q, sp_d, dpl_q, dpl_d, dph_q, dph_d;
  logic [7:0]         ie_q, ie_d, p1_q, p1_d;
  logic [7:1]         psw_q, psw_d;
  logic [7:0]         psw_view;
  logic               in_service_q, in_service_d;
  logic [CODE_AW-1:0] code_addr_q, code_addr_d;
  logic               rd_vld_q, rd_vld_d;
  rd_src_e            rd_src_q, rd_src_d;
  logic [7:0]         sfr_rdata, sfr_rdata_q, return_q, return_d;
  logic               iram_we, sfr_we;
  logic [7:0]         iram_rdata;
  logic [1:0]         int0_sync_q, int1_sync_q;
  logic               pending, int_q, int_d;

  assign daddr    = eu.EU_REGISTER_R3[7:0];
  assign wdata    = eu.EU_BIU_DATAOUT;
  assign psw_view = {psw_q, ^acc_q};
  // Edge-detected issue; live_q blocks a strobe that was already present across reset release.
  assign cmd = (live_q && (eu.EU_BIU_STROBE != strobe_q)) ? eu.EU_BIU_STROBE : BIU_CMD_IDLE;

  always_comb begin
    sfr_rdata = 8'h00;
    case (daddr)
      SFR_ACC_ADDR: sfr_rdata = acc_q;
      SFR_B_ADDR:   sfr_rdata = b_q;
      SFR_PSW_ADDR: sfr_rdata = psw_view;
      SFR_SP_ADDR:  sfr_rdata = sp_q;
      SFR_DPL_ADDR: sfr_rdata = dpl_q;
      SFR_DPH_ADDR: sfr_rdata = dph_q;
      SFR_IE_ADDR:  sfr_rdata = ie_q;
      SFR_P1_ADDR:  sfr_rdata = p1_q;
      default:      sfr_rdata = 8'h00;
    endcase
  end

`ifdef MCL51_BIU_XDATA_EN
  logic xdata_we;
  assign XDATA_ADDR  = {dph_q, dpl_q};
  assign XDATA_WDATA = wdata;
  assign XDATA_WE    = xdata_we;
`endif

  always_comb begin
    acc_d        = acc_q;
    b_d          = b_q;
    psw_d        = psw_q;
    sp_d         = sp_q;
    dpl_d        = dpl_q;
    dph_d        = dph_q;
    ie_d         = ie_q;
    p1_d         = p1_q;
    in_service_d = in_service_q;
    code_addr_d  = code_addr_q;
    rd_vld_d     = 1'b0;
    rd_src_d     = SrcZero;
    iram_we      = 1'b0;
    sfr_we       = 1'b0;
`ifdef MCL51_BIU_XDATA_EN
    xdata_we     = 1'b0;
`endif
    case (cmd)
      BIU_CMD_CODE_IP: begin
        rd_vld_d    = 1'b1;
        rd_src_d    = SrcCode;
        code_addr_d = eu.EU_REGISTER_IP[CODE_AW-1:0];
      end
      BIU_CMD_CODE_R3: begin
        rd_vld_d    = 1'b1;
        rd_src_d    = SrcCode;
        code_addr_d = eu.EU_REGISTER_R3[CODE_AW-1:0];
      end
      BIU_CMD_DIR_RD: begin
        rd_vld_d = 1'b1;
        rd_src_d = daddr[7] ? SrcSfr : SrcIram;
      end
      BIU_CMD_DIR_WR: begin
        sfr_we  = daddr[7];
        iram_we = !daddr[7];
      end
      BIU_CMD_IND_RD: begin
        rd_vld_d = 1'b1;
        rd_src_d = (HasUpper || !daddr[7]) ? SrcIram : SrcZero;
      end
      BIU_CMD_IND_WR:  iram_we = HasUpper || !daddr[7];
      BIU_CMD_ACC_WR:  acc_d = wdata;
      BIU_CMD_PSW_WR:  psw_d = wdata[7:1];
      BIU_CMD_SP_WR:   sp_d = wdata;
      BIU_CMD_DPL_WR:  dpl_d = wdata;
      BIU_CMD_DPH_WR:  dph_d = wdata;
      BIU_CMD_INT_ACK: in_service_d = 1'b1;
      BIU_CMD_RETI:    in_service_d = 1'b0;
`ifdef MCL51_BIU_XDATA_EN
      BIU_CMD_XDATA_RD: begin
        rd_vld_d = 1'b1;
        rd_src_d = SrcXdata;
      end
      BIU_CMD_XDATA_WR: xdata_we = 1'b1;
`endif
      default: ;
    endcase
    if (sfr_we) begin
      case (daddr)
        SFR_ACC_ADDR: acc_d = wdata;
        SFR_B_ADDR:   b_d = wdata;
        SFR_PSW_ADDR: psw_d = wdata[7:1];
        SFR_SP_ADDR:  sp_d = wdata;
        SFR_DPL_ADDR: dpl_d = wdata;
        SFR_DPH_ADDR: dph_d = wdata;
        SFR_IE_ADDR:  ie_d = wdata;
        SFR_P1_ADDR:  p1_d = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    return_d = return_q;
    if (rd_vld_q) begin
      case (rd_src_q)
        SrcCode:  return_d = CODE_DATA;
        SrcIram:  return_d = iram_rdata;
        SrcSfr:   return_d = sfr_rdata_q;
`ifdef MCL51_BIU_XDATA_EN
        SrcXdata: return_d = XDATA_RDATA;
`endif
        default:  return_d = 8'h00;
      endcase
    end
  end

  // Using the next in-service value lets an acknowledge drop the request in the very next cycle.
  assign pending = (~int0_sync_q[1] & ie_q[0]) | (~int1_sync_q[1] & ie_q[2]);
  assign int_d   = pending & ie_q[7] & ~in_service_d;

  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) begin
      live_q       <= 1'b0;
      strobe_q     <= 8'h00;
      acc_q        <= 8'h00;
      b_q          <= 8'h00;
      psw_q        <= 7'h00;
      sp_q         <= SP_RESET;
      dpl_q        <= 8'h00;
      dph_q        <= 8'h00;
      ie_q         <= 8'h00;
      p1_q         <= 8'hFF;
      in_service_q <= 1'b0;
      code_addr_q  <= '0;
      rd_vld_q     <= 1'b0;
      rd_src_q     <= SrcZero;
      sfr_rdata_q  <= 8'h00;
      return_q     <= 8'h00;
      int0_sync_q  <= 2'b11;
      int1_sync_q  <= 2'b11;
      int_q        <= 1'b0;
    end else begin
      live_q       <= 1'b1;
      strobe_q     <= eu.EU_BIU_STROBE;
      acc_q        <= acc_d;
      b_q          <= b_d;
      psw_q        <= psw_d;
      sp_q         <= sp_d;
      dpl_q        <= dpl_d;
      dph_q        <= dph_d;
      ie_q         <= ie_d;
      p1_q         <= p1_d;
      in_service_q <= in_service_d;
      code_addr_q  <= code_addr_d;
      rd_vld_q     <= rd_vld_d;
      rd_src_q     <= rd_src_d;
      sfr_rdata_q  <= sfr_rdata;
      return_q     <= return_d;
      int0_sync_q  <= {int0_sync_q[0], INT0_n};
      int1_sync_q  <= {int1_sync_q[0], INT1_n};
      int_q        <= int_d;
    end
  end

  mcl51_biu_iram #(
    .Depth (IRAM_DEPTH),
    .Aw    (IramAw)
  ) u_iram (
    .clk   (CORE_CLK),
    .addr  (daddr[IramAw-1:0]),
    .we    (iram_we),
    .wdata (wdata),
    .rdata (iram_rdata)
  );

  assign CODE_ADDR           = code_addr_d;
  assign P1_OUT              = p1_q;
  assign eu.BIU_RETURN_DATA  = return_q;
  assign eu.BIU_SFR_ACC      = acc_q;
  assign eu.BIU_SFR_DPTR     = {dph_q, dpl_q};
  assign eu.BIU_SFR_SP       = sp_q;
  assign eu.BIU_SFR_PSW      = psw_view;
  assign eu.BIU_INTERRUPT    = int_q;
endmodule

// File: tb/tb_mcl51_biu.sv
// Self-checking bench for mcl51_biu: directed scenarios plus randomized commands checked
// against an architectural model (IRAM/SFR arrays, ROM table).
module tb_mcl51_biu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] code_addr;
  logic [7:0]  code_data = 8'h00;
  logic        int0_n = 1'b1;
  logic        int1_n = 1'b1;
  logic [7:0]  p1_out;
  int          n_total = 0;
  int          n_bad = 0;

  logic [7:0] rom [65536];
  logic [7:0] m_iram [256];
  logic [7:0] m_acc, m_b, m_sp, m_dpl, m_dph, m_ie, m_p1, m_ret;
  logic [7:1] m_psw;

  mcl51_biu_if eu_if ();

  always #5 clk = ~clk;
  always @(posedge clk) code_data <= rom[code_addr];

`ifdef MCL51_BIU_XDATA_EN
  logic [15:0] xdata_addr;
  logic [7:0]  xdata_wdata, xdata_rdata;
  logic        xdata_we;
  always @(posedge clk) xdata_rdata <= xdata_addr[7:0] ^ xdata_addr[15:8];
`endif

  mcl51_biu dut (
    .CORE_CLK    (clk),
    .RST_n       (rst_n),
    .eu          (eu_if.slave),
    .CODE_ADDR   (code_addr),
    .CODE_DATA   (code_data),
    .INT0_n      (int0_n),
    .INT1_n      (int1_n),
    .P1_OUT      (p1_out)
`ifdef MCL51_BIU_XDATA_EN
    ,
    .XDATA_ADDR  (xdata_addr),
    .XDATA_WDATA (xdata_wdata),
    .XDATA_WE    (xdata_we),
    .XDATA_RDATA (xdata_rdata)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_acc = 8'h00; m_b = 8'h00; m_psw = 7'h00; m_sp = 8'h07;
    m_dpl = 8'h00; m_dph = 8'h00; m_ie = 8'h00; m_p1 = 8'hFF; m_ret = 8'h00;
  endtask

  function automatic logic [7:0] m_sfr_rd(input logic [7:0] a);
    case (a)
      8'hE0:   return m_acc;
      8'hF0:   return m_b;
      8'hD0:   return {m_psw, ^m_acc};
      8'h81:   return m_sp;
      8'h82:   return m_dpl;
      8'h83:   return m_dph;
      8'hA8:   return m_ie;
      8'h90:   return m_p1;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_sfr_wr(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'hE0: m_acc = d;
      8'hF0: m_b = d;
      8'hD0: m_psw = d[7:1];
      8'h81: m_sp = d;
      8'h82: m_dpl = d;
      8'h83: m_dph = d;
      8'hA8: m_ie = d;
      8'h90: m_p1 = d;
      default: ;
    endcase
  endtask

  task automatic check_sfrs(input string tag);
    check({tag, ".acc"}, eu_if.BIU_SFR_ACC, m_acc);
    check({tag, ".psw"}, eu_if.BIU_SFR_PSW, {m_psw, ^m_acc});
    check({tag, ".sp"}, eu_if.BIU_SFR_SP, m_sp);
    check({tag, ".dptr"}, eu_if.BIU_SFR_DPTR, {m_dph, m_dpl});
    check({tag, ".p1"}, p1_out, m_p1);
  endtask

  // One command: issue in T, strobe back to idle in T+1 (write results checked), data at T+2.
  task automatic do_cmd(input string tag, input logic [7:0] c, input logic [15:0] r3,
                        input logic [15:0] ip, input logic [7:0] d);
    logic [7:0] a;
    logic       is_rd;
    logic [7:0] rv;
    a = r3[7:0];
    is_rd = 1'b1;
    rv = 8'h00;
    eu_if.EU_BIU_STROBE  = c;
    eu_if.EU_REGISTER_R3 = r3;
    eu_if.EU_REGISTER_IP = ip;
    eu_if.EU_BIU_DATAOUT = d;
    case (c)
      8'h01: rv = rom[ip];
      8'h02: rv = rom[r3];
      8'h03: rv = (a < 8'h80) ? m_iram[a] : m_sfr_rd(a);
      8'h05: rv = m_iram[a];
      default: is_rd = 1'b0;
    endcase
    @(negedge clk);
    eu_if.EU_BIU_STROBE = 8'h00;
    case (c)
      8'h04: if (a < 8'h80) m_iram[a] = d; else m_sfr_wr(a, d);
      8'h06: m_iram[a] = d;
      8'h07: m_acc = d;
      8'h08: m_psw = d[7:1];
      8'h09: m_sp = d;
      8'h0A: m_dpl = d;
      8'h0B: m_dph = d;
      default: ;
    endcase
    check_sfrs(tag);
    check({tag, ".irq"}, eu_if.BIU_INTERRUPT, 1'b0);
    @(negedge clk);
    if (is_rd) m_ret = rv;
    check({tag, ".ret"}, eu_if.BIU_RETURN_DATA, m_ret);
  endtask

  initial begin
    logic got;
    logic [7:0] c;
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[16'h0010] = 8'hA5;
    eu_if.EU_BIU_STROBE  = 8'h00;
    eu_if.EU_BIU_DATAOUT = 8'h00;
    eu_if.EU_REGISTER_R3 = 16'h0000;
    eu_if.EU_REGISTER_IP = 16'h0000;
    m_reset();

    // Power-on reset
    repeat (3) @(negedge clk);
    check_sfrs("por");
    check("por.ret", eu_if.BIU_RETURN_DATA, 8'h00);
    check("por.irq", eu_if.BIU_INTERRUPT, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill IRAM with known contents through indirect writes
    for (int i = 0; i < 256; i++) do_cmd("fill", 8'h06, 16'(i), 16'h0000, 8'($urandom));

    // Direct and SFR paths
    do_cmd("dir_wr30", 8'h04, 16'h0030, 16'h0000, 8'h5A);
    do_cmd("dir_rd30", 8'h03, 16'h0030, 16'h0000, 8'h00);
    check("dir_rd30.val", eu_if.BIU_RETURN_DATA, 8'h5A);
    do_cmd("acc_wr", 8'h04, 16'h00E0, 16'h0000, 8'h07);
    check("acc_wr.acc", eu_if.BIU_SFR_ACC, 8'h07);
    check("acc_wr.par", eu_if.BIU_SFR_PSW[0], 1'b1);
    do_cmd("unmapped", 8'h03, 16'h00B5, 16'h0000, 8'h00);
    check("unmapped.val", eu_if.BIU_RETURN_DATA, 8'h00);
    do_cmd("psw_ro", 8'h08, 16'h0000, 16'h0000, 8'hFE);
    check("psw_ro.val", eu_if.BIU_SFR_PSW, 8'hFF);

    // Upper IRAM via indirect access must not disturb P1
    do_cmd("ind_wr90", 8'h06, 16'h0090, 16'h0000, 8'h3C);
    do_cmd("ind_rd90", 8'h05, 16'h0090, 16'h0000, 8'h00);
    check("ind_rd90.val", eu_if.BIU_RETURN_DATA, 8'h3C);
    check("ind_rd90.p1", p1_out, 8'hFF);

    // Code read with the strobe held: executes once, later IP changes ignored
    eu_if.EU_REGISTER_IP = 16'h0010;
    eu_if.EU_BIU_STROBE  = 8'h01;
    #1 check("code.addr_t", code_addr, 16'h0010);
    @(negedge clk);
    eu_if.EU_REGISTER_IP = 16'h0020;
    #1 check("code.addr_t1", code_addr, 16'h0010);
    @(negedge clk);
    check("code.ret", eu_if.BIU_RETURN_DATA, 8'hA5);
    check("code.addr_t2", code_addr, 16'h0010);
    @(negedge clk);
    check("code.addr_t3", code_addr, 16'h0010);
    check("code.ret_hold", eu_if.BIU_RETURN_DATA, 8'hA5);
    eu_if.EU_BIU_STROBE = 8'h00;
    m_ret = 8'hA5;
    @(negedge clk);

    // Interrupt raise, acknowledge, RETI
    do_cmd("ie_wr", 8'h04, 16'h00A8, 16'h0000, 8'h85);
    int0_n = 1'b0;
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (eu_if.BIU_INTERRUPT) got = 1'b1;
    end
    check("irq.raise", got, 1'b1);
    eu_if.EU_BIU_STROBE = 8'h0C;
    @(negedge clk);
    check("irq.ack", eu_if.BIU_INTERRUPT, 1'b0);
    eu_if.EU_BIU_STROBE = 8'h00;
    repeat (2) @(negedge clk);
    check("irq.in_service", eu_if.BIU_INTERRUPT, 1'b0);
    eu_if.EU_BIU_STROBE = 8'h0D;
    @(negedge clk);
    check("irq.reti", eu_if.BIU_INTERRUPT, 1'b1);
    eu_if.EU_BIU_STROBE = 8'h00;
    int0_n = 1'b1;
    repeat (4) @(negedge clk);
    check("irq.release", eu_if.BIU_INTERRUPT, 1'b0);
    do_cmd("ie_clr", 8'h04, 16'h00A8, 16'h0000, 8'h00);

`ifdef MCL51_BIU_XDATA_EN
    do_cmd("x_dpl", 8'h0A, 16'h0000, 16'h0000, 8'h34);
    do_cmd("x_dph", 8'h0B, 16'h0000, 16'h0000, 8'h12);
    eu_if.EU_BIU_DATAOUT = 8'h99;
    eu_if.EU_BIU_STROBE  = 8'h0F;
    #1;
    check("xwr.we", xdata_we, 1'b1);
    check("xwr.addr", xdata_addr, 16'h1234);
    check("xwr.wdata", xdata_wdata, 8'h99);
    @(negedge clk);
    check("xwr.we_t1", xdata_we, 1'b0);
    @(negedge clk);
    check("xwr.we_t2", xdata_we, 1'b0);
    eu_if.EU_BIU_STROBE = 8'h0E;
    @(negedge clk);
    eu_if.EU_BIU_STROBE = 8'h00;
    @(negedge clk);
    m_ret = 8'h12 ^ 8'h34;
    check("xrd.ret", eu_if.BIU_RETURN_DATA, m_ret);
`endif

    // Reset asserted mid-command, strobe still held after release: no write may land
    eu_if.EU_BIU_STROBE  = 8'h04;
    eu_if.EU_REGISTER_R3 = 16'h0030;
    eu_if.EU_BIU_DATAOUT = 8'hEE;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    check_sfrs("rst");
    check("rst.irq", eu_if.BIU_INTERRUPT, 1'b0);
    check("rst.ret", eu_if.BIU_RETURN_DATA, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    eu_if.EU_BIU_STROBE = 8'h00;
    @(negedge clk);
    do_cmd("rst_rd30", 8'h03, 16'h0030, 16'h0000, 8'h00);
    check("rst_rd30.val", eu_if.BIU_RETURN_DATA, 8'h5A);

    // Randomized command stream against the model
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      c = (r < 16) ? 8'(r) : 8'(8'h10 + $urandom_range(0, 239));
`ifdef MCL51_BIU_XDATA_EN
      if (c == 8'h0E || c == 8'h0F) c = 8'h03;
`endif
      do_cmd("rnd", c, 16'($urandom), 16'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mcl51_biu.md
Name: mcl51_biu

Overview:
- Bus Interface Unit for the MCL51 core; the responder side of the EU strobe interface.
- Decodes EU command strobes and performs code-ROM, internal-RAM and SFR accesses.
- Owns the architectural SFRs (ACC, PSW, SP, DPTR, B, IE, P1), drives return data and SFR views back to the EU, and raises the interrupt request flag.
- Sits between the EU microsequencer and the memories, in the MCL51 core top level.

Parameters:
- CODE_AW, 16, code ROM address width
- IRAM_DEPTH, 256, internal RAM bytes (128 or 256)
- SP_RESET, 8'h07, stack pointer reset value

Ports:
- CORE_CLK  in  1  core clock
- RST_n  in  1  asynchronous active-low reset
- EU_BIU_STROBE  in  8  command code from EU; 8'h00 = idle
- EU_BIU_DATAOUT  in  8  write data from EU
- EU_REGISTER_R3  in  16  data/code address from EU
- EU_REGISTER_IP  in  16  program counter from EU
- BIU_RETURN_DATA  out  8  read result
- BIU_SFR_ACC  out  8  ACC
- BIU_SFR_DPTR  out  16  {DPH,DPL}
- BIU_SFR_SP  out  8  SP
- BIU_SFR_PSW  out  8  PSW, bit0 = live ACC parity
- BIU_INTERRUPT  out  1  interrupt request to EU
- CODE_ADDR  out  CODE_AW  synchronous code ROM address
- CODE_DATA  in  8  code ROM data, valid one cycle after CODE_ADDR
- INT0_n, INT1_n  in  1 each  external interrupts, active-low level, asynchronous
- P1_OUT  out  8  port 1 latch

Behaviour:
- Reset values (asynchronous, RST_n low):
  - ACC=0, B=0, PSW=0, DPTR=0, IE=0
  - SP=SP_RESET, P1_OUT=8'hFF
  - BIU_RETURN_DATA=0, BIU_INTERRUPT=0
  - in-service flag=0, previous-strobe register=0, command pipeline cleared
- Command issue:
  - A command issues in cycle T when EU_BIU_STROBE != 0 and EU_BIU_STROBE != its value in T-1.
  - A strobe held for multiple cycles executes once.
  - A direct change from one non-zero code to another issues the new command.
- Commands:
  - 01 code read at IP
  - 02 code read at R3
  - 03 direct read at R3[7:0]: <80h is IRAM, >=80h is SFR
  - 04 direct write DATAOUT to R3[7:0]
  - 05 indirect IRAM read at R3[7:0]
  - 06 indirect IRAM write
  - 07 write ACC
  - 08 write PSW[7:1]
  - 09 write SP
  - 0A write DPL
  - 0B write DPH
  - 0C interrupt acknowledge: set in-service
  - 0D RETI: clear in-service
  - Others: no operation.
- SFR map: ACC E0, B F0, PSW D0, SP 81, DPL 82, DPH 83, IE A8, P1 90.
  - Unmapped SFR reads return 00; writes to them are ignored.
  - PSW bit0 is read-only; writes to it are ignored.
- Read latency:
  - Memory address is presented in T; data is captured at the end of T+1; BIU_RETURN_DATA is valid from T+2.
  - BIU_RETURN_DATA holds until the next read command completes.
  - Microcode spaces BIU reads at least 2 microinstructions apart.
- Writes:
  - Take effect at the end of T; the SFR outputs reflect the new value in T+1.
  - A read in the same cycle as a write to that location returns the old value.
- Indirect at or above 80h with IRAM_DEPTH=128: read returns 00; write is ignored.
- Interrupts:
  - INT0_n and INT1_n each pass through a 2-flop synchronizer.
  - pending = (~INT0s & IE[0]) | (~INT1s & IE[2]).
  - BIU_INTERRUPT = registered (pending & IE[7] & ~in_service).
  - Command 0C drops BIU_INTERRUPT the following cycle.
- Parity: PSW[0] = ^ACC, combinational from the ACC register.

Optional Feature:
- Macro MCL51_BIU_XDATA_EN.
- When defined:
  - Adds ports XDATA_ADDR out 16 (driven from DPTR), XDATA_WDATA out 8, XDATA_WE out 1, XDATA_RDATA in 8.
  - Command 0E is a MOVX read at DPTR, with the same 2-cycle latency as other reads.
  - Command 0F is a MOVX write of DATAOUT; XDATA_WE pulses for exactly one cycle (T).
- When undefined: the ports are absent and 0E/0F are no-ops.

Decomposition:
- Package mcl51_pkg holds:
  - command code constants (BIU_CMD_*)
  - SFR address constants (SFR_ACC_ADDR etc.)
  - PSW bit index constants
- One sub-module, mcl51_biu_iram: IRAM_DEPTH x 8 synchronous single-port RAM with 1-cycle read.

Test Plan:
- Reset: hold RST_n low mid-command -> SP=07, P1_OUT=FF, ACC=0, BIU_INTERRUPT=0; no memory write occurs after reset releases.
- Code read: IP=0010, strobe 00->01; ROM[0010]=A5 -> BIU_RETURN_DATA=A5 at T+2; the strobe held for 3 more cycles causes no further CODE_ADDR change.
- Direct/SFR path:
  - strobe 04 with R3=0030, DATAOUT=5A, then 03 at R3=0030 -> return 5A.
  - 04 at R3=00E0, DATAOUT=07 -> BIU_SFR_ACC=07 and PSW[0]=1 at T+1.
  - 03 at R3=00B5 -> return 00.
- Indirect upper RAM: IRAM_DEPTH=256, 06 then 05 at R3=0090 with data 3C -> return 3C; P1_OUT unchanged at FF.
- Interrupt:
  - IE=85, INT0_n low -> BIU_INTERRUPT=1 within 3 cycles.
  - strobe 0C -> BIU_INTERRUPT=0 the next cycle.
  - 0D with INT0_n still low -> BIU_INTERRUPT returns to 1.
- XDATA (macro defined): DPTR=1234, strobe 0F, DATAOUT=99 -> XDATA_WE high for exactly one cycle with XDATA_ADDR=1234.
